// File: rtl/result_queue_drain.sv
// result_queue_drain
//   Consumer end of the fractal result queue. Iteration counts pushed by the
//   compute state machine are buffered in a small circular FIFO and drained
//   into a registered valid/ready pixel stream. Each count is mapped to a
//   colour and tagged with start-of-frame / end-of-line markers.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   push          producer writes push_iter this cycle
//   push_iter     iteration count of the next pixel (raster order)
//   full_queue    FIFO holds DEPTH entries; producer must stall
//   overflow      sticky: a push arrived while full_queue was high
//   m_valid       output pixel present
//   m_ready       downstream accepts the pixel
//   m_data        colour {R,G,B}, ITER_W bits per channel
//   m_sof         presented pixel is x=0, y=0
//   m_eol         presented pixel is x=WIDTH-1
//   frame_done    one-cycle pulse after the last pixel of a frame is accepted
module result_queue_drain #(
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480,
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 255,
  parameter int DEPTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [ITER_W-1:0]     push_iter,
  output logic                  full_queue,
  output logic                  overflow,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [3*ITER_W-1:0]   m_data,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  frame_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [CW-1:0]     COUNT_FULL = CW'(DEPTH);
  localparam logic [XW-1:0]     X_LAST     = XW'(WIDTH - 1);
  localparam logic [YW-1:0]     Y_LAST     = YW'(HEIGHT - 1);
  localparam logic [ITER_W-1:0] ITER_MAX   = ITER_W'(MAX_ITER);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t            state_reg;
  logic [ITER_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic [XW-1:0]     x_reg;
  logic [YW-1:0]     y_reg;
  logic              last_reg;      // presented pixel closes the frame

  logic                push_ok;
  logic                pop;
  logic                fire;
  logic [ITER_W-1:0]   head;
  logic [3*ITER_W-1:0] head_colour;

  assign full_queue = (count_reg == COUNT_FULL);
  assign push_ok    = push && !full_queue;
  assign fire       = m_valid && m_ready;
  // The output register is refilled whenever it is empty or being emptied
  // this cycle, as long as the FIFO has something to give.
  assign pop        = (count_reg != '0) && ((state_reg == S_EMPTY) || m_ready);
  assign head       = mem[rd_ptr_reg];

  always_comb begin
    head_colour = '0;
    if (head != ITER_MAX) begin
      head_colour = {head, ~head, head << 1};
    end
  end

  // Storage array; pointers are reset separately so no reset is needed here.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr_reg] <= push_iter;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_EMPTY;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      last_reg   <= 1'b0;
      overflow   <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_sof      <= 1'b0;
      m_eol      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= fire && last_reg;

      // A push while full is dropped, even if a pop frees a slot this cycle.
      if (push && full_queue) begin
        overflow <= 1'b1;
      end

      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end

      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase

      // Load the output register and advance the raster position.
      if (pop) begin
        m_data   <= head_colour;
        m_sof    <= (x_reg == '0) && (y_reg == '0);
        m_eol    <= (x_reg == X_LAST);
        last_reg <= (x_reg == X_LAST) && (y_reg == Y_LAST);
        if (x_reg == X_LAST) begin
          x_reg <= '0;
          y_reg <= (y_reg == Y_LAST) ? '0 : y_reg + 1'b1;
        end else begin
          x_reg <= x_reg + 1'b1;
        end
      end

      case (state_reg)
        S_EMPTY: begin
          if (pop) begin
            state_reg <= S_FULL;
            m_valid   <= 1'b1;
          end
        end
        S_FULL: begin
          if (m_ready && !pop) begin
            state_reg <= S_EMPTY;
            m_valid   <= 1'b0;
          end
        end
        default: begin
          state_reg <= S_EMPTY;
          m_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule
